// File: rtl/neuron_requant.sv
// Output requantizer: round-half-up, arithmetic shift and saturation to int8, then an FWFT FIFO.
// Optional ReLU after saturation when NEURON_REQUANT_RELU_EN is defined.
module neuron_requant #(
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_sum,
    input  logic               in_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [7:0]  out_data,
    output logic               out_sat,
    output logic [15:0]        sat_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    // Half an output LSB; this expression is zero when SHIFT is zero.
    localparam logic signed [17:0] ROUND = 18'((1 << SHIFT) >> 1);

    logic signed [17:0] w_v;
    logic signed [17:0] w_r;
    logic signed [17:0] w_q;
    logic        [7:0]  w_data;
    logic               w_sat;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic        [8:0]  w_head;

    logic               r_s1_valid;
    logic        [7:0]  r_s1_data;
    logic               r_s1_sat;
    logic        [8:0]  r_mem [DEPTH];
    logic      [AW-1:0] r_wr_ptr;
    logic      [AW-1:0] r_rd_ptr;
    logic      [CW-1:0] r_count;
    logic        [15:0] r_sat_count;

    assign w_v = {in_carry, in_carry, in_sum};
    assign w_r = w_v + ROUND;
    assign w_q = w_r >>> SHIFT;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_data = w_q[7:0];
        w_sat  = 1'b0;
`ifdef NEURON_REQUANT_RELU_EN
        if (w_q[17]) begin
            w_data = 8'h00;
        end else if (w_q > 18'sd127) begin
            w_data = 8'h7F;
            w_sat  = 1'b1;
        end
`else
        if (w_q > 18'sd127) begin
            w_data = 8'h7F;
            w_sat  = 1'b1;
        end else if (w_q < -18'sd128) begin
            w_data = 8'h80;
            w_sat  = 1'b1;
        end
`endif
    end

    // The stage-1 word already holds a FIFO slot, so room is reserved before it is pushed.
    assign in_ready  = (r_count + CW'(r_s1_valid)) < CW'(DEPTH);
    assign w_accept  = in_valid && in_ready;
    assign w_push    = r_s1_valid;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_sat    <= 1'b0;
            r_sat_count <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= w_data;
                r_s1_sat  <= w_sat;
                if (w_sat && (r_sat_count != 16'hFFFF)) begin
                    r_sat_count <= r_sat_count + 16'd1;
                end
            end
        end
    end

    // NOTE: the storage array is not reset; contents are only observable through out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_s1_sat, r_s1_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is gated so the outputs read zero whenever the FIFO is empty, including after reset.
    assign w_head    = r_mem[r_rd_ptr];
    assign out_data  = out_valid ? $signed(w_head[7:0]) : 8'sd0;
    assign out_sat   = out_valid ? w_head[8] : 1'b0;
    assign sat_count = r_sat_count;

endmodule

// File: tb/tb_neuron_requant.sv
// Scoreboard bench for neuron_requant (SHIFT=4, DEPTH=4): directed vectors, backpressure,
// full-rate stream, reset flush and saturation-counter limit.
module tb_neuron_requant;

    localparam int SH = 4;
    localparam int DP = 4;
`ifdef NEURON_REQUANT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       sat;
    } exp_t;

    typedef struct packed {
        logic        c;
        logic [15:0] s;
        logic [7:0]  d;
        logic        sat;
    } vec_t;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_sum;
    logic               in_carry;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_data;
    logic               out_sat;
    logic [15:0]        sat_count;

    neuron_requant #(.SHIFT(SH), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_pop = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[14];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: floor((v + 2^(SH-1)) / 2^SH), then clamp and optional ReLU.
    function automatic exp_t model(input logic c, input logic [15:0] s);
        int   v;
        int   num;
        int   q;
        int   pw;
        exp_t e;
        pw  = 1 << SH;
        v   = c ? int'(s) - 65536 : int'(s);
        num = v + pw / 2;
        q   = (num >= 0) ? num / pw : -((-num + pw - 1) / pw);
        e.sat = 1'b0;
        if (q > 127) begin
            e.d = 8'h7F; e.sat = 1'b1;
        end else if (q < -128) begin
            e.d = 8'h80; e.sat = 1'b1;
        end else begin
            e.d = 8'(q);
        end
        if (RELU && q < 0) begin
            e.d = 8'h00; e.sat = 1'b0;
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic c, input logic [15:0] s, input logic [7:0] d, input logic sat);
        vec_t v;
        v.c = c; v.s = s; v.d = d; v.sat = sat;
        return v;
    endfunction

    function automatic exp_t ev(input vec_t v);
        exp_t e;
        e.d = v.d; e.sat = v.sat;
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT completes an output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", {24'd0, out_data}, 32'(mon_e.d));
                check("out_sat", 32'(out_sat), 32'(mon_e.sat));
                n_pop++;
            end
        end
    end

    task automatic send(input logic c, input logic [15:0] s, input exp_t e);
        in_valid = 1'b1; in_carry = c; in_sum = s;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Single word into an idle pipe: out_valid must be low after the accept edge, high after the next.
    task automatic send_timed(input vec_t v);
        in_valid = 1'b1; in_carry = v.c; in_sum = v.s;
        @(negedge clk);
        check("ready_at_present", 32'(in_ready), 32'd1);
        sb.push_back(ev(v));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_on_time", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int base;
        int t0;
        int t1;
        logic [15:0] rs;
        logic        rc;

        vecs[0]  = mk(1'b0, 16'h0100, 8'h10, 1'b0);
        vecs[1]  = mk(1'b0, 16'h0018, 8'h02, 1'b0);
        vecs[2]  = mk(1'b0, 16'h0017, 8'h01, 1'b0);
        vecs[3]  = mk(1'b1, 16'hFFE8, RELU ? 8'h00 : 8'hFF, 1'b0);
        vecs[4]  = mk(1'b0, 16'h7FFF, 8'h7F, 1'b1);
        vecs[5]  = mk(1'b1, 16'h8000, RELU ? 8'h00 : 8'h80, !RELU);
        vecs[6]  = mk(1'b0, 16'h0550, 8'h55, 1'b0);
        vecs[7]  = mk(1'b1, 16'hF9C0, RELU ? 8'h00 : 8'h9C, 1'b0);
        vecs[8]  = mk(1'b0, 16'h07F7, 8'h7F, 1'b0);
        vecs[9]  = mk(1'b0, 16'h07F8, 8'h7F, 1'b1);
        vecs[10] = mk(1'b1, 16'hF7F8, RELU ? 8'h00 : 8'h80, 1'b0);
        vecs[11] = mk(1'b1, 16'hF7F7, RELU ? 8'h00 : 8'h80, !RELU);
        vecs[12] = mk(1'b1, 16'h0000, RELU ? 8'h00 : 8'h80, !RELU);
        vecs[13] = mk(1'b0, 16'hFFFF, 8'h7F, 1'b1);

        rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Rounding with exact two-cycle latency.
        for (int i = 0; i < 4; i++) send_timed(vecs[i]);
        // Saturation pair, then the counter.
        for (int i = 4; i < 6; i++) send(vecs[i].c, vecs[i].s, ev(vecs[i]));
        in_valid = 1'b0;
        check("sat_count_pair", 32'(sat_count), RELU ? 32'd1 : 32'd2);
        // Clamp boundaries and extremes, streamed back to back.
        for (int i = 6; i < 14; i++) send(vecs[i].c, vecs[i].s, ev(vecs[i]));
        in_valid = 1'b0;
        check("sat_count_bounds", 32'(sat_count), RELU ? 32'd3 : 32'd6);
        drain();

        // Backpressure: six offered words, four fit.
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_carry = 1'b0; in_sum = 16'((i + 1) * 160);
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(1'b0, 16'((i + 1) * 160)));
                n_acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(n_acc), 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_stall_valid", 32'(out_valid), 32'd1);
            check("bp_stall_data", {24'd0, out_data}, 32'h0A);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Full-rate random stream: no bubble between first and last output.
        base = n_pop;
        t0 = 0; t1 = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    rs = 16'($urandom);
                    rc = 1'($urandom);
                    send(rc, rs, model(rc, rs));
                end
                in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 400; t++) begin
                    @(negedge clk); #1;
                    if (n_pop >= base + 1) begin t0 = cyc; break; end
                end
                for (int t = 0; t < 400; t++) begin
                    if (n_pop >= base + 100) begin t1 = cyc; break; end
                    @(negedge clk); #1;
                end
            end
        join
        check("fullrate_span", 32'(t1 - t0), 32'd99);
        drain();

        // Reset with three words buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 16'h7FFF, model(1'b0, 16'h7FFF));
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #2;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sat_count", 32'(sat_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("postrst_no_stale", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Counter saturation at 0xFFFF.
        for (int i = 0; i < 65534; i++) send(1'b0, 16'h7FFF, model(1'b0, 16'h7FFF));
        check("satcnt_fffe", 32'(sat_count), 32'hFFFE);
        send(1'b0, 16'h7FFF, model(1'b0, 16'h7FFF));
        check("satcnt_ffff", 32'(sat_count), 32'hFFFF);
        send(1'b0, 16'h7FFF, model(1'b0, 16'h7FFF));
        send(1'b0, 16'h7FFF, model(1'b0, 16'h7FFF));
        in_valid = 1'b0;
        check("satcnt_hold", 32'(sat_count), 32'hFFFF);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
